// File: rtl/nexys_starship_damage_gen.sv
// ---------------------------------------------------------------------------
// nexys_starship_damage_gen
//
// Purpose: drives random "damage" events into the four starship repair units.
// After a pseudo-random number of game-timer ticks, it picks an unbroken unit
// and raises that unit's strobe together with a repair combo. It then waits
// for the unit to report itself broken, or for a timeout, before arming the
// next countdown.
//
// Handshake (strobe / acknowledge):
//   rand_strobe[i] is the request and broken_vec[i] is the acknowledge. The
//   strobe is asserted from the edge that enters FIRE and held, together with
//   a stable random_hex, until one of these happens:
//     - broken_vec[target] is sampled high. The strobe drops on that edge and
//       the break is counted.
//     - ACK_TIMEOUT Clk cycles pass without acknowledge. The strobe drops and
//       the break is not counted.
//     - gameover_ctrl or Reset is asserted.
//   At most one strobe bit is ever high.
//
// Ports:
//   Clk            system clock
//   Reset          synchronous active-high reset
//   timer_tick     one-cycle pulse at the game-timer rate
//   play_flag      game start request (honoured in IDLE)
//   gameover_ctrl  game end; aborts ARMED/FIRE back to IDLE
//   broken_vec     {down, up, right, left} broken flags from the repair units
//   rand_strobe    one-hot break request, same bit order as broken_vec
//   random_hex     repair combo for the strobed unit (never 0)
//   damage_count   acknowledged breaks this game, saturating at 255
//   all_broken     registered (broken_vec == 4'hF)
//   dbg_state      current FSM state (0 IDLE, 1 ARMED, 2 FIRE)
//
// Build option:
//   DAMAGE_GEN_ESCALATE_EN  When defined, the countdown base shrinks as
//                           damage accumulates:
//                           max(2, BASE_TICKS - damage_count[7:3]).
//                           When undefined, the base is always BASE_TICKS.
// ---------------------------------------------------------------------------
module nexys_starship_damage_gen #(
  parameter int unsigned BASE_TICKS  = 8,
  parameter int unsigned ACK_TIMEOUT = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       timer_tick,
  input  logic       play_flag,
  input  logic       gameover_ctrl,
  input  logic [3:0] broken_vec,
  output logic [3:0] rand_strobe,
  output logic [3:0] random_hex,
  output logic [7:0] damage_count,
  output logic       all_broken,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FIRE  = 2'd2
  } state_t;

  localparam int FW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [FW-1:0] FIRE_LAST = FW'(ACK_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [7:0]    tick_q, tick_d;
  logic [1:0]    target_q, target_d;
  logic [3:0]    strobe_q, strobe_d;
  logic [3:0]    hex_q, hex_d;
  logic [7:0]    count_q, count_d;
  logic          allb_q, allb_d;
  logic [FW-1:0] fire_q, fire_d;

  logic [7:0]    count_inc;
  logic [7:0]    base;
  logic [7:0]    reload;
  logic [1:0]    pick;
  logic [3:0]    hex_pick;

  // Saturating increment for the damage counter.
  assign count_inc = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;

`ifdef DAMAGE_GEN_ESCALATE_EN
  // The base uses the count that takes effect on the reload edge:
  // 0 on game start, the incremented count on acknowledge, and the
  // unchanged count on timeout.
  logic [7:0] count_rl;
  int         base_i;

  always_comb begin
    count_rl = count_q;
    if (state_q == S_IDLE) begin
      count_rl = 8'd0;
    end else if (state_q == S_FIRE && broken_vec[target_q]) begin
      count_rl = count_inc;
    end
  end

  always_comb begin
    base_i = int'(BASE_TICKS) - int'(count_rl[7:3]);
    if (base_i < 2) begin
      base_i = 2;
    end
    base = 8'(base_i);
  end
`else
  assign base = 8'(BASE_TICKS);
`endif

  // The tick loaded on a reload edge replaces the countdown, so a timer_tick
  // arriving on that same edge has no effect.
  assign reload = base + {4'b0000, lfsr_q[3:0]};

  // Target search. Start at candidate lfsr[5:4] and take the first unbroken
  // unit at offsets 0..3, wrapping mod 4. The loop runs from the highest
  // offset down so that the smallest offset is assigned last and wins.
  always_comb begin
    pick = lfsr_q[5:4];
    for (int k = 3; k >= 0; k--) begin
      if (!broken_vec[lfsr_q[5:4] + 2'(k)]) begin
        pick = lfsr_q[5:4] + 2'(k);
      end
    end
  end

  // A zero combo is not a valid repair code, so it is replaced by 4'hF.
  assign hex_pick = (lfsr_q[11:8] == 4'h0) ? 4'hF : lfsr_q[11:8];

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    target_d = target_q;
    strobe_d = strobe_q;
    hex_d    = hex_q;
    count_d  = count_q;
    fire_d   = fire_q;
    allb_d   = (broken_vec == 4'hF);
    // Galois LFSR, mask 16'hB400, shifting right. It runs in every state.
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    unique case (state_q)
      S_IDLE: begin
        strobe_d = 4'b0000;
        if (play_flag) begin
          state_d = S_ARMED;
          count_d = 8'd0;
          tick_d  = reload;
        end
      end

      S_ARMED: begin
        strobe_d = 4'b0000;
        if (gameover_ctrl) begin
          state_d = S_IDLE;
        end else if (tick_q != 8'd0) begin
          if (timer_tick) begin
            tick_d = tick_q - 8'd1;
          end
        end else if (broken_vec != 4'hF) begin
          // When every unit is already broken, the block waits here with
          // the countdown at zero until some unit is repaired.
          state_d  = S_FIRE;
          target_d = pick;
          strobe_d = 4'b0001 << pick;
          hex_d    = hex_pick;
          fire_d   = '0;
        end
      end

      S_FIRE: begin
        if (gameover_ctrl) begin
          state_d  = S_IDLE;
          strobe_d = 4'b0000;
        end else if (broken_vec[target_q]) begin
          state_d  = S_ARMED;
          strobe_d = 4'b0000;
          count_d  = count_inc;
          tick_d   = reload;
        end else if (fire_q == FIRE_LAST) begin
          state_d  = S_ARMED;
          strobe_d = 4'b0000;
          tick_d   = reload;
        end else begin
          fire_d = fire_q + FW'(1);
        end
      end

      default: begin
        state_d  = S_IDLE;
        strobe_d = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      lfsr_q   <= LFSR_SEED;
      tick_q   <= 8'd0;
      target_q <= 2'd0;
      strobe_q <= 4'b0000;
      hex_q    <= 4'h0;
      count_q  <= 8'd0;
      allb_q   <= 1'b0;
      fire_q   <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      tick_q   <= tick_d;
      target_q <= target_d;
      strobe_q <= strobe_d;
      hex_q    <= hex_d;
      count_q  <= count_d;
      allb_q   <= allb_d;
      fire_q   <= fire_d;
    end
  end

  assign rand_strobe  = strobe_q;
  assign random_hex   = hex_q;
  assign damage_count = count_q;
  assign all_broken   = allb_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_nexys_starship_damage_gen.sv
// ---------------------------------------------------------------------------
// Bench for nexys_starship_damage_gen.
//
// A cycle model of the game rules runs on every rising edge. A compare process
// checks all DUT outputs against that model on every falling edge. Directed
// scenarios add hand-computed literal checks, which also pin the model.
// ---------------------------------------------------------------------------
module tb_nexys_starship_damage_gen;

  localparam int BASE_TICKS  = 8;
  localparam int ACK_TIMEOUT = 8;

  logic       Clk;
  logic       Reset;
  logic       timer_tick;
  logic       play_flag;
  logic       gameover_ctrl;
  logic [3:0] broken_vec;
  logic [3:0] rand_strobe;
  logic [3:0] random_hex;
  logic [7:0] damage_count;
  logic       all_broken;
  logic [1:0] dbg_state;

  nexys_starship_damage_gen #(
    .BASE_TICKS (BASE_TICKS),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .timer_tick   (timer_tick),
    .play_flag    (play_flag),
    .gameover_ctrl(gameover_ctrl),
    .broken_vec   (broken_vec),
    .rand_strobe  (rand_strobe),
    .random_hex   (random_hex),
    .damage_count (damage_count),
    .all_broken   (all_broken),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int tick_mode = 0;  // 0 none, 1 every cycle, 2 every other cycle

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_phase;  // 0 idle, 1 armed, 2 fire
  logic [15:0] m_lfsr;
  int          m_ticks;
  int          m_target;
  int          m_hex;
  int          m_count;
  int          m_age;
  bit          m_allb;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int base_for(input int cnt);
    int b;
    b = BASE_TICKS;
`ifdef DAMAGE_GEN_ESCALATE_EN
    b = BASE_TICKS - cnt / 8;
    if (b < 2) b = 2;
`endif
    return b;
  endfunction

  task automatic m_step();
    logic [15:0] lf;
    int cand;
    int found;
    if (Reset) begin
      m_phase = 0; m_lfsr = 16'hACE1; m_ticks = 0; m_target = 0;
      m_hex = 0; m_count = 0; m_age = 0; m_allb = 0;
      return;
    end
    lf = m_lfsr;
    m_lfsr = lfsr_step(lf);
    m_allb = (broken_vec == 4'hF);
    if (m_phase == 0) begin
      if (play_flag) begin
        m_phase = 1;
        m_count = 0;
        m_ticks = base_for(0) + int'(lf[3:0]);
      end
      return;
    end
    if (gameover_ctrl) begin
      m_phase = 0;
      return;
    end
    if (m_phase == 1) begin
      if (m_ticks > 0) begin
        if (timer_tick) m_ticks--;
        return;
      end
      if (broken_vec == 4'hF) return;
      cand  = int'(lf[5:4]);
      found = -1;
      for (int k = 0; k < 4; k++)
        if (found < 0 && !broken_vec[(cand + k) % 4]) found = (cand + k) % 4;
      m_target = found;
      m_hex    = (lf[11:8] == 4'h0) ? 15 : int'(lf[11:8]);
      m_age    = 0;
      m_phase  = 2;
      return;
    end
    if (broken_vec[m_target]) begin
      m_count = (m_count < 255) ? m_count + 1 : 255;
      m_phase = 1;
      m_ticks = base_for(m_count) + int'(lf[3:0]);
      return;
    end
    m_age++;
    if (m_age == ACK_TIMEOUT) begin
      m_phase = 1;
      m_ticks = base_for(m_count) + int'(lf[3:0]);
    end
  endtask

  always @(posedge Clk) m_step();

  // ---------------- compare process ----------------
  always @(negedge Clk) begin
    if (chk_en) begin
      check("model_strobe", 32'(rand_strobe), (m_phase == 2) ? (32'd1 << m_target) : 32'd0);
      check("model_hex",    32'(random_hex),   32'(m_hex));
      check("model_count",  32'(damage_count), 32'(m_count));
      check("model_allb",   32'(all_broken),   32'(m_allb));
      check("model_state",  32'(dbg_state),    32'(m_phase));
    end
  end

  // ---------------- drivers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  bit tog = 1'b0;
  initial begin
    timer_tick = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      tog = ~tog;
      if (tick_mode == 1)      timer_tick = 1'b1;
      else if (tick_mode == 2) timer_tick = tog;
      else if (tick_mode != 3) timer_tick = 1'b0;
    end
  end

  task automatic wait_fire(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (rand_strobe != 4'b0000) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: strobe never rose within 400 cycles", name);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  logic [3:0] saved_hex;
  logic [3:0] saved_strobe;
  logic [3:0] pats [11];
  int         hi;

  initial begin
    Reset = 1'b1; play_flag = 1'b0; gameover_ctrl = 1'b0; broken_vec = 4'b0000;
    pats = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100,
             4'b0101, 4'b1010, 4'b1110, 4'b1101, 4'b1011};
    cyc(3);
    chk_en = 1'b1;
    check("rst_strobe", 32'(rand_strobe), 0);
    check("rst_hex",    32'(random_hex), 0);
    check("rst_count",  32'(damage_count), 0);
    check("rst_allb",   32'(all_broken), 0);
    check("rst_state",  32'(dbg_state), 0);

    // The first free-running edge steps the seed once.
    Reset = 1'b0;
    cyc(1);
    check("lfsr_pin", 32'(m_lfsr), 32'h0000E270);

    // Play on lfsr=E270: the countdown loads 8 + 0.
    play_flag = 1'b1;
    cyc(1);
    play_flag = 1'b0;
    check("play_state", 32'(dbg_state), 1);
    check("play_ticks", 32'(m_ticks), 8);
    for (int i = 0; i < 8; i++) begin
      timer_tick = 1'b1; tick_mode = 3;
      cyc(1);
      tick_mode = 0; timer_tick = 1'b0;
      check("countdown_quiet", 32'(rand_strobe), 0);
      cyc(1);
      if (i < 7) check("countdown_quiet", 32'(rand_strobe), 0);
    end
    check("fire_onehot", 32'($onehot(rand_strobe)), 1);

    // Acknowledge after 3 cycles.
    saved_hex = random_hex;
    saved_strobe = rand_strobe;
    check("hex_nonzero", 32'(random_hex != 4'h0), 1);
    cyc(3);
    check("hex_stable", 32'(random_hex), 32'(saved_hex));
    check("strobe_stable", 32'(rand_strobe), 32'(saved_strobe));
    broken_vec = saved_strobe;
    cyc(1);
    check("ack_drop", 32'(rand_strobe), 0);
    check("ack_count", 32'(damage_count), 1);
    check("ack_hex_hold", 32'(random_hex), 32'(saved_hex));
    broken_vec = 4'b0000;

    // Only unit 3 is unbroken.
    broken_vec = 4'b0111;
    tick_mode = 1;
    wait_fire("wrap_fire");
    tick_mode = 0;
    check("wrap_strobe", 32'(rand_strobe), 32'b1000);
    check("allb_low", 32'(all_broken), 0);
    broken_vec = 4'hF;
    cyc(1);
    check("wrap_count", 32'(damage_count), 2);
    check("allb_high", 32'(all_broken), 1);
    tick_mode = 1;
    cyc(40);
    check("allbroken_nostrobe", 32'(rand_strobe), 0);
    check("allbroken_armed", 32'(dbg_state), 1);

    // Timeout: the strobe stays high for exactly ACK_TIMEOUT cycles.
    broken_vec = 4'b0000;
    wait_fire("timeout_fire");
    tick_mode = 0;
    hi = 1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (rand_strobe == 4'b0000) break;
      hi++;
    end
    check("timeout_len", 32'(hi), 8);
    check("timeout_count", 32'(damage_count), 2);
    check("timeout_state", 32'(dbg_state), 1);

    // Game over during FIRE, then a new game.
    tick_mode = 1;
    wait_fire("gameover_fire");
    gameover_ctrl = 1'b1;
    cyc(1);
    gameover_ctrl = 1'b0;
    check("gameover_strobe", 32'(rand_strobe), 0);
    check("gameover_state", 32'(dbg_state), 0);
    check("gameover_count", 32'(damage_count), 2);
    cyc(3);
    play_flag = 1'b1;
    cyc(1);
    play_flag = 1'b0;
    check("replay_count", 32'(damage_count), 0);

    // Mixed patterns, with ticks arriving on the reload edges.
    for (int i = 0; i < 11; i++) begin
      broken_vec = pats[i];
      tick_mode = (i % 2 == 0) ? 1 : 2;
      wait_fire("pattern_fire");
      check("pattern_onehot", 32'($onehot(rand_strobe)), 1);
      check("pattern_unbroken", 32'((rand_strobe & pats[i]) == 4'b0000), 1);
      cyc(i % 4);
      if (i % 3 != 2) begin
        broken_vec = pats[i] | rand_strobe;
        cyc(1);
        check("pattern_ack", 32'(rand_strobe), 0);
      end else begin
        cyc(ACK_TIMEOUT);
      end
      broken_vec = 4'b0000;
      cyc(2);
    end

    // Reset during FIRE drops the strobe on the same edge.
    tick_mode = 1;
    wait_fire("reset_fire");
    Reset = 1'b1;
    cyc(1);
    Reset = 1'b0;
    check("rst_fire_strobe", 32'(rand_strobe), 0);
    check("rst_fire_state", 32'(dbg_state), 0);
    tick_mode = 0;
    cyc(4);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
